// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer that owns the PC register write port.
// Optional macro PC_SEQ_TIMEOUT_EN adds an IMEM acknowledge timeout in FETCH.
//
// state  | meaning
// RESET  | post-reset idle, moves to FETCH one cycle after rst drops
// FETCH  | imem_req high at the latched PC, waiting for imem_ack
// EXEC   | instruction held valid until the core retires it
// UPDATE | one-cycle PC write of the selected next PC
// EXC    | one-cycle PC write of EXC_VECTOR with exc_ack
// HALT   | stopped, waits for exc_req
module pc_sequencer #(
   parameter logic [31:0] RESET_PC     = 32'h00400000,
   parameter logic [31:0] EXC_VECTOR   = 32'h00400004,
   parameter int unsigned IMEM_TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic        pc_write,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   output logic        instr_valid,
   input  logic        instr_retire,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp_valid,
   input  logic [31:0] jmp_target,
   input  logic        exc_req,
   output logic        exc_ack,
   input  logic        halt,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_UPDATE = 3'd3,
      S_EXC    = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_next_q;
   logic [31:0] imem_addr_q;
   logic        halt_pend;
   logic [31:0] target;
   logic        retire_now;
   logic        misaligned;
   logic        timeout;

   if (IMEM_TIMEOUT == 0) begin : g_bad_timeout
      $error("IMEM_TIMEOUT must be nonzero");
   end

   // Jump beats branch beats sequential; the adder wraps silently.
   always_comb begin
      target = pc_cur + 32'd4;
      if (jmp_valid)
         target = jmp_target;
      else if (br_taken)
         target = br_target;
   end

   assign misaligned = (target[1:0] != 2'b00);
   // An exception in the retire cycle discards the redirect.
   assign retire_now = (state == S_EXEC) && instr_retire && !exc_req;

`ifdef PC_SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(IMEM_TIMEOUT + 1);
   logic [CNT_W-1:0] fetch_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_cnt <= CNT_W'(IMEM_TIMEOUT - 1);
      else if (state != S_FETCH)
         fetch_cnt <= CNT_W'(IMEM_TIMEOUT - 1);
      else if (fetch_cnt != '0)
         fetch_cnt <= fetch_cnt - 1'b1;
   end

   assign timeout = (state == S_FETCH) && (fetch_cnt == '0);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_RESET;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RESET:  state_nxt = S_FETCH;
         S_FETCH: begin
            if (exc_req)
               state_nxt = S_EXC;
            else if (imem_ack)
               state_nxt = S_EXEC;
            else if (timeout)
               state_nxt = S_EXC;
         end
         S_EXEC: begin
            if (exc_req)
               state_nxt = S_EXC;
            else if (instr_retire)
               state_nxt = misaligned ? S_EXC : S_UPDATE;
         end
         S_UPDATE: begin
            if (exc_req)
               state_nxt = S_EXC;
            else if (halt_pend)
               state_nxt = S_HALT;
            else
               state_nxt = S_FETCH;
         end
         S_EXC:    state_nxt = S_FETCH;
         S_HALT: begin
            if (exc_req)
               state_nxt = S_EXC;
         end
         default:  state_nxt = S_RESET;
      endcase
   end

   // The PC register updates on the negedge of the write cycle, so pc_cur
   // already holds the new value when FETCH is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_next_q   <= RESET_PC;
         imem_addr_q <= RESET_PC;
         halt_pend   <= 1'b0;
      end else begin
         if (retire_now) begin
            halt_pend <= halt;
            if (!misaligned)
               pc_next_q <= target;
         end
         if ((state_nxt == S_FETCH) && (state != S_FETCH))
            imem_addr_q <= pc_cur;
      end
   end

   always_comb begin
      pc_write    = 1'b0;
      pc_next     = pc_next_q;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      exc_ack     = 1'b0;
      busy        = 1'b1;
      case (state)
         S_FETCH:  imem_req = 1'b1;
         S_EXEC:   instr_valid = 1'b1;
         S_UPDATE: pc_write = 1'b1;
         S_EXC: begin
            pc_write = 1'b1;
            pc_next  = EXC_VECTOR;
            exc_ack  = 1'b1;
         end
         S_HALT:   busy = 1'b0;
         default: ;
      endcase
   end

   assign imem_addr = imem_addr_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control block that owns the PC register's write port and sequences instruction fetch.
- Issues fetch requests to instruction memory.
- Holds the fetched instruction valid until the core retires it.
- Selects the next PC from sequential, branch, jump or exception sources, then pulses the PC write enable for exactly one cycle.
- Sits between the PC register, the IMEM port and the control unit's retire/redirect outputs.

Parameters:
RESET_PC, 32'h00400000, value `pc_cur` is expected to hold after reset; also `imem_addr` reset value.
EXC_VECTOR, 32'h00400004, PC loaded on any exception.
IMEM_TIMEOUT, 8, max cycles in FETCH waiting for `imem_ack` (used only with the optional feature).

Ports:
- clk, input, 1, system clock; FSM on posedge (PC register captures on negedge of the same cycle).
- rst, input, 1, reset, asynchronous, active-high.
- pc_cur, input, 32, current PC register value.
- pc_write, output, 1, one-cycle PC write strobe.
- pc_next, output, 32, data to PC register; valid while `pc_write`=1.
- imem_req, output, 1, fetch request; held until `imem_ack`.
- imem_addr, output, 32, fetch address (= `pc_cur` latched on entering FETCH).
- imem_ack, input, 1, IMEM data returned this cycle.
- instr_valid, output, 1, fetched instruction available to the core.
- instr_retire, input, 1, core finished current instruction.
- br_taken, input, 1, taken branch; sampled with `instr_retire`.
- br_target, input, 32, branch target.
- jmp_valid, input, 1, jump/jr; sampled with `instr_retire`.
- jmp_target, input, 32, jump target.
- exc_req, input, 1, external/internal exception request; level.
- exc_ack, output, 1, one-cycle pulse when vector is written.
- halt, input, 1, stop fetching after current retire.
- busy, output, 1, high in every state except HALT.

Behaviour:
- Reset values: state=RESET, `pc_write`=0, `pc_next`=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `exc_ack`=0, `busy`=1.
- States:
  - RESET -> FETCH one cycle after `rst` deasserts.
  - FETCH: `imem_req`=1, `imem_addr` = latched `pc_cur`. On `imem_ack` -> EXEC.
  - EXEC: `instr_valid`=1. On `instr_retire` compute next PC -> UPDATE.
  - UPDATE: `pc_write`=1 with registered `pc_next` for one cycle. Next state is HALT if `halt` was sampled at retire, else FETCH.
  - EXC: `pc_write`=1, `pc_next`=EXC_VECTOR, `exc_ack`=1 for one cycle -> FETCH.
  - HALT: all strobes 0, `busy`=0. Leaves only on `exc_req` (-> EXC) or `rst`.
- Next-PC priority at retire: `jmp_valid` > `br_taken` > sequential `pc_cur`+32'd4.
  - Addition is modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000, no flag.
- Alignment: a selected target with bits [1:0] != 0 is not written. The FSM goes to EXC instead.
- Exceptions:
  - `exc_req` in FETCH or EXEC preempts: -> EXC next cycle, current fetch/instruction abandoned, `instr_valid` drops.
  - `exc_req` in UPDATE: let the UPDATE write complete, then EXC.
  - `exc_req` and `instr_retire` in the same cycle: exception wins and the retire redirect is discarded.
  - `exc_req` still high after `exc_ack`: re-taken only after the following FETCH begins, i.e. at most one EXC per two cycles.
- `imem_ack` outside FETCH: ignored. `instr_retire` outside EXEC: ignored.
- `rst` mid-operation: immediate return to reset values; any pending write is dropped.
- Latency, no stalls: reset release -> first `imem_req` in 1 cycle. Fetch + retire + update minimum is 3 cycles per instruction.

Optional Feature:
Macro PC_SEQ_TIMEOUT_EN.
- Defined: a counter runs in FETCH. If `imem_ack` has not arrived after IMEM_TIMEOUT cycles, `imem_req` drops and the FSM enters EXC (`pc_next`=EXC_VECTOR). The counter clears on leaving FETCH.
- Undefined: no counter; FETCH waits indefinitely.

Test Plan:
1. Release `rst`, `pc_cur`=32'h00400000, `imem_ack` 1 cycle after `imem_req`, `instr_retire` next cycle, no redirect -> `pc_write` one cycle with `pc_next`=32'h00400004; next `imem_addr`=32'h00400004.
2. Retire with `br_taken`=1, `br_target`=32'h00400100 and `jmp_valid`=1, `jmp_target`=32'h00400200 -> `pc_next`=32'h00400200. Repeat with `jmp_valid`=0 -> 32'h00400100.
3. Retire with `jmp_target`=32'h00400102 -> no write of 32'h00400102; EXC writes 32'h00400004 and `exc_ack` pulses once.
4. `exc_req` and `instr_retire` in the same EXEC cycle with `br_taken` -> only the EXC_VECTOR write occurs. `pc_cur`=32'hFFFFFFFC with sequential retire -> `pc_next`=32'h00000000.
5. `halt`=1 at retire -> UPDATE write, then `busy`=0 and no `imem_req`. Then `exc_req` -> EXC write of 32'h00400004, fetch resumes.
6. With PC_SEQ_TIMEOUT_EN and `imem_ack` held low -> after 8 FETCH cycles `imem_req`=0 and EXC writes 32'h00400004. Without the macro -> `imem_req` stays high for 20+ cycles.
